// File: rtl/conversor_display_seq_pkg.sv
// conversor_display_seq_pkg: shared base codes, FSM states and the "0" glyph
package conversor_display_seq_pkg;
  localparam logic [1:0] BASE_DEC = 2'b00;
  localparam logic [1:0] BASE_OCT = 2'b01;
  localparam logic [1:0] BASE_HEX = 2'b10;
  localparam logic [1:0] BASE_SIG = 2'b11;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  typedef enum logic [1:0] {OCIOSO, CARREGA, DESLOCA, PRONTO} estado_t;
endpackage

// File: rtl/conversor_display_seq_decodificador7seg.sv
// decodificador7seg: 4-bit digit to active-low 7-segment glyph (gfedcba)
//   digito    in  4  digit code 0..F
//   segmentos out 7  active-low segments, bit 6 = g
module decodificador7seg
  import conversor_display_seq_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] segmentos
);
  always_comb begin
    segmentos = SEG_ZERO;
    case (digito)
      4'h1: segmentos = 7'b1111001;
      4'h2: segmentos = 7'b0100100;
      4'h3: segmentos = 7'b0110000;
      4'h4: segmentos = 7'b0011001;
      4'h5: segmentos = 7'b0010010;
      4'h6: segmentos = 7'b0000010;
      4'h7: segmentos = 7'b1111000;
      4'h8: segmentos = 7'b0000000;
      4'h9: segmentos = 7'b0010000;
      4'hA: segmentos = 7'b0001000;
      4'hB: segmentos = 7'b0000011;
      4'hC: segmentos = 7'b1000110;
      4'hD: segmentos = 7'b0100001;
      4'hE: segmentos = 7'b0000110;
      4'hF: segmentos = 7'b0001110;
      default: segmentos = SEG_ZERO;
    endcase
  end
endmodule

// File: rtl/conversor_display_seq.sv
// conversor_display_seq: multi-cycle double-dabble converter driving three 7-seg displays
//   CLOCK/RESET (async, active-low); Start samples Resultado[7:0] and Base[1:0]
//   (00 dec, 01 oct, 10 hex, 11 signed dec); Busy while converting; Pronto pulses
//   with each display update; SinalNegativo sign LED; DisplayUnidade/Dezena/Centena
//   active-low segments. Macro DISPLAY_SIGNED_EN enables signed decimal on Base=11.
module conversor_display_seq
  import conversor_display_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [WIDTH-1:0] Resultado,
  input  logic [1:0]       Base,
  output logic             Busy,
  output logic             Pronto,
  output logic             SinalNegativo,
  output logic [6:0]       DisplayUnidade,
  output logic [6:0]       DisplayDezena,
  output logic [6:0]       DisplayCentena
);
  localparam int DW = 4 * DIGITS;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  estado_t estado, prox;
  logic [WIDTH-1:0] op, bin, mag;
  logic [1:0] base_r;
  logic [DW-1:0] bcd, bcd_adj;
  logic [CW-1:0] cnt;
  logic neg, neg_in, decimal, aceita;
  logic [DIGITS-1:0][3:0] dig, dig_nxt;
  logic [DIGITS-1:0][6:0] seg;
  assign decimal = base_r == BASE_DEC || base_r == BASE_SIG;
  assign aceita = (estado == OCIOSO || estado == PRONTO) && Start;
`ifdef DISPLAY_SIGNED_EN
  assign neg_in = base_r == BASE_SIG && op[WIDTH-1];
`else
  assign neg_in = 1'b0;
`endif
  assign mag = neg_in ? -op : op;
  always_comb begin
    prox = estado;
    Busy = estado == CARREGA || estado == DESLOCA;
    prox = aceita ? CARREGA
         : estado == CARREGA ? DESLOCA
         : estado == DESLOCA ? (cnt == CW'(WIDTH - 1) ? PRONTO : DESLOCA)
         : OCIOSO;
  end
  // Add-3 correction only in decimal; oct/hex just shift the plain binary in.
  always_comb begin
    bcd_adj = bcd;
    dig_nxt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = decimal && bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      dig_nxt[i] = decimal ? bcd[4*i +: 4]
                 : base_r == BASE_OCT ? {1'b0, bcd[3*i +: 3]}
                 : i == DIGITS - 1 ? 4'h0 : bcd[4*i +: 4];
    end
  end
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      estado <= OCIOSO;
      op <= '0;
      base_r <= BASE_DEC;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      neg <= 1'b0;
      dig <= '0;
      SinalNegativo <= 1'b0;
      Pronto <= 1'b0;
    end else begin
      estado <= prox;
      Pronto <= estado == PRONTO;
      if (estado == PRONTO) begin
        dig <= dig_nxt;
        SinalNegativo <= neg;
      end
      if (aceita) begin
        op <= Resultado;
        base_r <= Base;
        bcd <= '0;
        cnt <= '0;
      end
      if (estado == CARREGA) begin
        bin <= mag;
        neg <= neg_in;
      end
      if (estado == DESLOCA) begin
        {bcd, bin} <= {bcd_adj[DW-2:0], bin, 1'b0};
        cnt <= cnt + 1'b1;
      end
    end
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    decodificador7seg u_dec (.digito(dig[g]), .segmentos(seg[g]));
  end
  assign DisplayUnidade = seg[0];
  assign DisplayDezena  = seg[1];
  assign DisplayCentena = seg[DIGITS-1];
endmodule

// File: tb/tb_conversor_display_seq.sv
// tb_conversor_display_seq: directed self-checking bench for conversor_display_seq
module tb_conversor_display_seq;
  logic CLOCK = 1'b0, RESET = 1'b0, Start = 1'b0;
  logic [7:0] Resultado = '0;
  logic [1:0] Base = '0;
  logic Busy, Pronto, SinalNegativo;
  logic [6:0] DisplayUnidade, DisplayDezena, DisplayCentena;
  int vecs = 0, errs = 0;
  logic saw_pronto;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  conversor_display_seq dut (
    .CLOCK(CLOCK), .RESET(RESET), .Start(Start), .Resultado(Resultado), .Base(Base),
    .Busy(Busy), .Pronto(Pronto), .SinalNegativo(SinalNegativo),
    .DisplayUnidade(DisplayUnidade), .DisplayDezena(DisplayDezena),
    .DisplayCentena(DisplayCentena));
  always #5 CLOCK = ~CLOCK;
  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_disp(input string tag, input int c, input int d, input int u, input logic s);
    chk({tag, " centena"}, {1'b0, DisplayCentena}, {1'b0, SEG[c]});
    chk({tag, " dezena"}, {1'b0, DisplayDezena}, {1'b0, SEG[d]});
    chk({tag, " unidade"}, {1'b0, DisplayUnidade}, {1'b0, SEG[u]});
    chk({tag, " sinal"}, {7'b0, SinalNegativo}, {7'b0, s});
  endtask
  // Start edge is edge 0; displays must change exactly at edge 10.
  task automatic run(input string tag, input logic [7:0] v, input logic [1:0] b,
                     input int c, input int d, input int u, input logic s);
    Resultado = v;
    Base = b;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    Resultado = ~v;
    Base = ~b;
    chk({tag, " busy e0"}, {7'b0, Busy}, 8'd1);
    repeat (8) tick;
    chk({tag, " busy e8"}, {7'b0, Busy}, 8'd1);
    tick;
    chk({tag, " busy e9"}, {7'b0, Busy}, 8'd0);
    chk({tag, " pronto e9"}, {7'b0, Pronto}, 8'd0);
    tick;
    chk({tag, " pronto e10"}, {7'b0, Pronto}, 8'd1);
    chk_disp(tag, c, d, u, s);
    tick;
    chk({tag, " pronto e11"}, {7'b0, Pronto}, 8'd0);
    chk({tag, " hold"}, {1'b0, DisplayUnidade}, {1'b0, SEG[u]});
  endtask
  initial begin
    #12;
    chk("rst busy", {7'b0, Busy}, 8'd0);
    chk("rst pronto", {7'b0, Pronto}, 8'd0);
    chk_disp("rst", 0, 0, 0, 1'b0);
    RESET = 1'b1;
    tick;
    run("dec255", 8'd255, 2'b00, 2, 5, 5, 1'b0);
    run("hexAF", 8'hAF, 2'b10, 0, 10, 15, 1'b0);
    run("oct255", 8'd255, 2'b01, 3, 7, 7, 1'b0);
    run("dec0", 8'd0, 2'b00, 0, 0, 0, 1'b0);
    run("dec99", 8'd99, 2'b00, 0, 9, 9, 1'b0);
    run("hex07", 8'h07, 2'b10, 0, 0, 7, 1'b0);
`ifdef DISPLAY_SIGNED_EN
    run("sigFF", 8'hFF, 2'b11, 0, 0, 1, 1'b1);
    run("sig80", 8'h80, 2'b11, 1, 2, 8, 1'b1);
    run("sig05", 8'h05, 2'b11, 0, 0, 5, 1'b0);
`else
    run("sigFF", 8'hFF, 2'b11, 2, 5, 5, 1'b0);
    run("sig80", 8'h80, 2'b11, 1, 2, 8, 1'b0);
`endif
    run("dec128", 8'd128, 2'b00, 1, 2, 8, 1'b0);
    // Second Start while busy must be ignored.
    Resultado = 8'd255;
    Base = 2'b00;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    tick;
    tick;
    Resultado = 8'd17;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int i = 3; i < 9; i++) begin
      chk("ign busy", {7'b0, Busy}, 8'd1);
      tick;
    end
    tick;
    chk("ign pronto", {7'b0, Pronto}, 8'd1);
    chk_disp("ign", 2, 5, 5, 1'b0);
    tick;
    // Reset in the middle of a conversion.
    Resultado = 8'd99;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    repeat (5) tick;
    RESET = 1'b0;
    #1;
    chk("abort busy", {7'b0, Busy}, 8'd0);
    chk_disp("abort", 0, 0, 0, 1'b0);
    tick;
    RESET = 1'b1;
    saw_pronto = 1'b0;
    repeat (12) begin
      tick;
      saw_pronto |= Pronto;
    end
    chk("abort no pronto", {7'b0, saw_pronto}, 8'd0);
    chk_disp("abort after", 0, 0, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
